// File: rtl/gamepad_pmod_tx_pkg.sv
// Shared constants and FSM state type for the Gamepad Pmod transmitter.
// Frame layout and button ordering match the gamepad_pmod receivers.
package gamepad_pmod_tx_pkg;

  localparam int GP_BITS_PER_PAD = 12;
  localparam logic [GP_BITS_PER_PAD-1:0] GP_ABSENT_WORD = 12'hFFF;

  localparam int GP_B      = 11;
  localparam int GP_Y      = 10;
  localparam int GP_SELECT = 9;
  localparam int GP_START  = 8;
  localparam int GP_UP     = 7;
  localparam int GP_DOWN   = 6;
  localparam int GP_LEFT   = 5;
  localparam int GP_RIGHT  = 4;
  localparam int GP_A      = 3;
  localparam int GP_X      = 2;
  localparam int GP_L      = 1;
  localparam int GP_R      = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BIT_LO,
    ST_BIT_HI,
    ST_LATCH,
    ST_DONE,
    ST_GAP
  } state_t;

endpackage

// File: rtl/gamepad_pmod_tx_encoder.sv
// Combinational frame-word builder: the inverse of the receiver's decoder.
// Absent pads are sent as all-ones, which the receiver reads as "not connected".
module gamepad_pmod_tx_encoder
  import gamepad_pmod_tx_pkg::*;
#(
  parameter int NUM_PADS = 1
) (
  input  logic [GP_BITS_PER_PAD*NUM_PADS-1:0] buttons,
  input  logic [NUM_PADS-1:0]                 present,
  output logic [GP_BITS_PER_PAD*NUM_PADS-1:0] word
);

  always_comb begin
    word = '0;
    for (int p = 0; p < NUM_PADS; p++) begin
      word[p*GP_BITS_PER_PAD +: GP_BITS_PER_PAD] =
        present[p] ? buttons[p*GP_BITS_PER_PAD +: GP_BITS_PER_PAD] : GP_ABSENT_WORD;
    end
  end

endmodule

// File: rtl/gamepad_pmod_tx.sv
// Gamepad Pmod emulator: serialises a button snapshot onto pmod_data/pmod_clk/pmod_latch.
// Define GAMEPAD_PMOD_TX_AUTO_EN to add the auto_run port and free-running frames with a gap.
module gamepad_pmod_tx
  import gamepad_pmod_tx_pkg::*;
#(
  parameter int NUM_PADS  = 1,
  parameter int CLK_DIV   = 4,
  parameter int FRAME_GAP = 64
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [GP_BITS_PER_PAD*NUM_PADS-1:0]  buttons,
  input  logic [NUM_PADS-1:0]                  present,
  input  logic                                 start,
`ifdef GAMEPAD_PMOD_TX_AUTO_EN
  input  logic                                 auto_run,
`endif
  output logic                                 busy,
  output logic                                 frame_done,
  output logic                                 pmod_data,
  output logic                                 pmod_clk,
  output logic                                 pmod_latch
);

  localparam int FRAME_BITS = GP_BITS_PER_PAD * NUM_PADS;
  localparam int BIT_W      = $clog2(FRAME_BITS);
  // One counter serves both the clock divider and the inter-frame gap.
  localparam int CNT_MAX    = (CLK_DIV > FRAME_GAP) ? CLK_DIV : FRAME_GAP;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
`ifdef GAMEPAD_PMOD_TX_AUTO_EN
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(FRAME_GAP - 1);
`endif

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [BIT_W-1:0]        bit_cnt;
  logic [FRAME_BITS-1:0]   shreg;
  logic [FRAME_BITS-1:0]   word;
  logic                    launch;

  gamepad_pmod_tx_encoder #(.NUM_PADS(NUM_PADS)) u_encoder (
    .buttons (buttons),
    .present (present),
    .word    (word)
  );

  always_comb begin
    launch = (state == ST_IDLE) && start;
`ifdef GAMEPAD_PMOD_TX_AUTO_EN
    if (state == ST_GAP && (start || (cnt == GAP_LAST && auto_run))) launch = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      pmod_data  <= 1'b0;
      pmod_clk   <= 1'b0;
      pmod_latch <= 1'b0;
    end else if (launch) begin
      state     <= ST_BIT_LO;
      cnt       <= '0;
      bit_cnt   <= BIT_W'(FRAME_BITS - 1);
      shreg     <= word;
      busy      <= 1'b1;
      pmod_data <= word[FRAME_BITS-1];
    end else begin
      case (state)
        ST_IDLE: frame_done <= 1'b0;
        ST_BIT_LO: begin
          if (cnt == DIV_LAST) begin
            state    <= ST_BIT_HI;
            cnt      <= '0;
            pmod_clk <= 1'b1;
          end else cnt <= cnt + 1'b1;
        end
        ST_BIT_HI: begin
          if (cnt == DIV_LAST) begin
            cnt      <= '0;
            pmod_clk <= 1'b0;
            if (bit_cnt == '0) begin
              state      <= ST_LATCH;
              pmod_data  <= 1'b0;
              pmod_latch <= 1'b1;
            end else begin
              // Data only moves on the falling edge so the receiver never sees it change while clk is high.
              state     <= ST_BIT_LO;
              bit_cnt   <= bit_cnt - 1'b1;
              shreg     <= shreg << 1;
              pmod_data <= shreg[FRAME_BITS-2];
            end
          end else cnt <= cnt + 1'b1;
        end
        ST_LATCH: begin
          if (cnt == DIV_LAST) begin
            state      <= ST_DONE;
            cnt        <= '0;
            pmod_latch <= 1'b0;
            frame_done <= 1'b1;
            busy       <= 1'b0;
          end else cnt <= cnt + 1'b1;
        end
        ST_DONE: begin
          frame_done <= 1'b0;
`ifdef GAMEPAD_PMOD_TX_AUTO_EN
          state <= ST_GAP;
          cnt   <= '0;
`else
          state <= ST_IDLE;
`endif
        end
`ifdef GAMEPAD_PMOD_TX_AUTO_EN
        ST_GAP: begin
          if (cnt == GAP_LAST) state <= ST_IDLE;
          else                 cnt   <= cnt + 1'b1;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gamepad_pmod_tx.sv
// Self-checking bench for gamepad_pmod_tx (two pads, default build): a loopback receiver
// model captures the serial frame and compares it with the word derived from the input rules.
module tb_gamepad_pmod_tx;

  localparam int NP          = 2;
  localparam int CD          = 4;
  localparam int DONE_OFFSET = 2 * 12 * NP * CD + CD + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [23:0]   buttons;
  logic [1:0]    present;
  logic          start;
  logic          busy, frame_done, pmod_data, pmod_clk, pmod_latch;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [23:0] rx_shift = '0;
  logic [23:0] rx_word = '0;
  int          latch_count = 0;
  int          violations = 0;
  logic        prev_data = 1'b0;
  logic        prev_clk = 1'b0;
  logic [23:0] last_expected = '0;

  gamepad_pmod_tx #(.NUM_PADS(NP), .CLK_DIV(CD), .FRAME_GAP(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .buttons    (buttons),
    .present    (present),
    .start      (start),
    .busy       (busy),
    .frame_done (frame_done),
    .pmod_data  (pmod_data),
    .pmod_clk   (pmod_clk),
    .pmod_latch (pmod_latch)
  );

  always #5 clk = ~clk;

  // Loopback receiver: shift on pmod_clk rising edges, capture the word on latch.
  always @(posedge pmod_clk) rx_shift <= {rx_shift[22:0], pmod_data};
  always @(posedge pmod_latch) begin
    rx_word     <= rx_shift;
    latch_count <= latch_count + 1;
  end

  // Data must never change while pmod_clk is held high.
  always @(negedge clk) begin
    if (prev_clk && pmod_clk && (pmod_data !== prev_data)) violations <= violations + 1;
    prev_data <= pmod_data;
    prev_clk  <= pmod_clk;
  end

  function automatic logic [23:0] model_word(input logic [23:0] b, input logic [1:0] pr);
    int pad0, pad1;
    pad0 = pr[0] ? int'(b) % 4096 : 4095;
    pad1 = pr[1] ? int'(b) / 4096 : 4095;
    return 24'(pad1 * 4096 + pad0);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_cnt++;
    assert (observed === expected) pass_cnt++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic [23:0] b, input logic [1:0] pr, input bit disturb);
    logic [23:0] expected;
    int          cycles;
    int          latches_before;
    expected       = model_word(b, pr);
    latches_before = latch_count;
    @(negedge clk);
    buttons = b;
    present = pr;
    start   = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cycles = 1;
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    while (!frame_done && cycles < 400) begin
      @(negedge clk);
      cycles++;
      if (disturb && cycles == 60) begin
        buttons = 24'($urandom);
        present = 2'($urandom);
        start   = 1'b1;
      end else start = 1'b0;
    end
    checkOutput("done_latency", 32'(cycles), 32'(DONE_OFFSET));
    checkOutput("busy_in_done", 32'(busy), 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("done_pulse_width", 32'(frame_done), 32'd0);
    checkOutput("start_in_done_ignored", 32'(busy), 32'd0);
    checkOutput("rx_word", 32'(rx_word), 32'(expected));
    checkOutput("latch_per_frame", 32'(latch_count - latches_before), 32'd1);
    last_expected = expected;
  endtask

  initial begin
    int latches_before;
    rst_n   = 1'b0;
    start   = 1'b0;
    buttons = '0;
    present = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", 32'({busy, frame_done, pmod_data, pmod_clk, pmod_latch}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_outputs", 32'({busy, frame_done, pmod_data, pmod_clk, pmod_latch}), 32'd0);

    applyStimulus(24'h1230F0, 2'b01, 1'b0);
    checkOutput("absent_pad1_word", 32'(rx_word), 32'h00FFF0F0);
    applyStimulus({12'($urandom), 12'h801}, 2'b11, 1'b0);
    applyStimulus(24'hFFFFFF, 2'b11, 1'b0);
    applyStimulus(24'h000000, 2'b00, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(24'($urandom), 2'($urandom), 1'b1);

    // Abort a frame part way through the serial bits.
    latches_before = latch_count;
    @(negedge clk);
    buttons = 24'($urandom);
    present = 2'b11;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (41) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midframe_reset_outputs", 32'({busy, frame_done, pmod_data, pmod_clk, pmod_latch}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("midframe_reset_no_latch", 32'(latch_count - latches_before), 32'd0);
    checkOutput("midframe_reset_rx_kept", 32'(rx_word), 32'(last_expected));

    applyStimulus(24'($urandom), 2'b10, 1'b0);
    checkOutput("protocol_data_stable", 32'(violations), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
